// File: rtl/pacman_pkg.sv
// Shared types and maze geometry for the Pac-Man movement block and the ghost movers.
package pacman_pkg;

  localparam int TILE_SHIFT = 3;
  localparam int MAZE_COLS  = 28;
  localparam int MAZE_ROWS  = 31;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    FWD  = 2'd2
  } state_t;

  // The encoding pairs each direction with its reverse in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd1);
  endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// Tile-map lookup port: the mover drives a tile coordinate, the map answers combinationally.
interface pacman_motion_if;
  logic [4:0] query_col;
  logic [4:0] query_row;
  logic       query_wall;

  modport master (output query_col, output query_row, input query_wall);
  modport slave  (input query_col, input query_row, output query_wall);
endinterface

// File: rtl/pacman_tile_step.sv
// Combinational neighbour-tile and one-pixel step calculator with horizontal tunnel wrap.
module pacman_tile_step
  import pacman_pkg::*;
#(
  parameter int MAZE_W_PX = 224
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  dir_t       dir_i,
  output logic [4:0] nb_col_o,
  output logic [4:0] nb_row_o,
  output logic [9:0] nx_o,
  output logic [9:0] ny_o
);

  localparam logic [4:0] LAST_COL = 5'(MAZE_W_PX / (1 << TILE_SHIFT) - 1);
  localparam logic [9:0] LAST_X   = 10'(MAZE_W_PX - 1);

  logic [4:0] col;
  logic [4:0] row;

  assign col = x_i[TILE_SHIFT +: 5];
  assign row = y_i[TILE_SHIFT +: 5];

  // Rows never wrap: the maze border is solid, so the mover never steps past it.
  always_comb begin
    nb_col_o = col;
    nb_row_o = row;
    nx_o     = x_i;
    ny_o     = y_i;
    case (dir_i)
      RIGHT: begin
        nb_col_o = (col == LAST_COL) ? 5'd0 : col + 5'd1;
        nx_o     = (x_i == LAST_X) ? 10'd0 : x_i + 10'd1;
      end
      LEFT: begin
        nb_col_o = (col == 5'd0) ? LAST_COL : col - 5'd1;
        nx_o     = (x_i == 10'd0) ? LAST_X : x_i - 10'd1;
      end
      UP: begin
        nb_row_o = row - 5'd1;
        ny_o     = y_i - 10'd1;
      end
      DOWN: begin
        nb_row_o = row + 5'd1;
        ny_o     = y_i + 10'd1;
      end
    endcase
  end

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man mover: cornering at tile centres, reversal, tunnel wrap, mouth animation.
// Define PACMAN_TURN_BUFFER_EN to keep a pending turn request alive until it is taken (pre-turning).
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int START_X   = 119,
  parameter int START_Y   = 228,
  parameter int ALIGN_X   = 7,
  parameter int ALIGN_Y   = 4,
  parameter int MAZE_W_PX = 224,
  parameter int STEP_DIV  = 1,
  parameter int ANIM_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_tick,
  input  logic              req_valid,
  input  logic [1:0]        req_dir,
  pacman_motion_if.master   qry,
  output logic [9:0]        pacman_xloc,
  output logic [9:0]        pacman_yloc,
  output logic [1:0]        pacman_dir,
  output logic [1:0]        pacman_animation,
  output logic              moving
);

  localparam logic [2:0] AX        = 3'(ALIGN_X);
  localparam logic [2:0] AY        = 3'(ALIGN_Y);
  localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);
  localparam logic [3:0] ANIM_LAST = 4'(ANIM_DIV - 1);
  localparam logic [9:0] X0        = 10'(START_X);
  localparam logic [9:0] Y0        = 10'(START_Y);

  state_t     state_q;
  logic [9:0] x_q, y_q;
  dir_t       dir_q;
  logic [1:0] anim_q;
  logic       moving_q;
  logic       pend_valid_q;
  dir_t       pend_dir_q;
  logic [3:0] step_cnt_q;
  logic [3:0] anim_cnt_q;
  logic [4:0] qcol_q, qrow_q;

  dir_t       chk_dir;
  logic [4:0] nb_col, nb_row;
  logic [9:0] x_d, y_d;
  logic       centred;
  logic       tick_ok;

  // TURN probes the requested direction; FWD probes the (possibly just updated) heading.
  assign chk_dir = (state_q == TURN) ? pend_dir_q : dir_q;
  assign centred = (x_q[2:0] == AX) && (y_q[2:0] == AY);
  assign tick_ok = frame_tick & enable;

  pacman_tile_step #(.MAZE_W_PX(MAZE_W_PX)) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .dir_i    (chk_dir),
    .nb_col_o (nb_col),
    .nb_row_o (nb_row),
    .nx_o     (x_d),
    .ny_o     (y_d)
  );

  assign qry.query_col = (state_q == IDLE) ? qcol_q : nb_col;
  assign qry.query_row = (state_q == IDLE) ? qrow_q : nb_row;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= X0;
      y_q          <= Y0;
      dir_q        <= LEFT;
      anim_q       <= 2'd0;
      moving_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= LEFT;
      step_cnt_q   <= 4'd0;
      anim_cnt_q   <= 4'd0;
      qcol_q       <= X0[TILE_SHIFT +: 5];
      qrow_q       <= Y0[TILE_SHIFT +: 5];
    end else begin
      qcol_q <= qry.query_col;
      qrow_q <= qry.query_row;

      if (tick_ok && moving_q) begin
        if (anim_cnt_q == ANIM_LAST) begin
          anim_cnt_q <= 4'd0;
          anim_q     <= anim_q + 2'd1;
        end else begin
          anim_cnt_q <= anim_cnt_q + 4'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (tick_ok) begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= 4'd0;
              state_q    <= TURN;
            end else begin
              step_cnt_q <= step_cnt_q + 4'd1;
            end
          end
        end
        TURN: begin
          if (pend_valid_q && (pend_dir_q == opposite(dir_q))) begin
            dir_q        <= pend_dir_q;
            pend_valid_q <= 1'b0;
          end else if (pend_valid_q && (pend_dir_q != dir_q) && centred && !qry.query_wall) begin
            dir_q        <= pend_dir_q;
            pend_valid_q <= 1'b0;
          end
          state_q <= FWD;
        end
        FWD: begin
          if (centred && qry.query_wall) begin
            moving_q <= 1'b0;
          end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            moving_q <= 1'b1;
          end
`ifdef PACMAN_TURN_BUFFER_EN
          // The request stays armed until a later centre lets it through.
`else
          pend_valid_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Placed last so a same-cycle request overrides any consumption above.
      if (req_valid) begin
        pend_dir_q   <= dir_t'(req_dir);
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign pacman_xloc      = x_q;
  assign pacman_yloc      = y_q;
  assign pacman_dir       = dir_q;
  assign pacman_animation = anim_q;
  assign moving           = moving_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed and randomized bench for pacman_motion against a frame-level behavioural model.
module tb_pacman_motion;

  localparam int ANIM_DIV = 4;
  localparam int MAZE_W   = 224;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       frame_tick;
  logic       req_valid;
  logic [1:0] req_dir;
  logic [9:0] pacman_xloc, pacman_yloc;
  logic [1:0] pacman_dir, pacman_animation;
  logic       moving;

  logic wall_map [0:31][0:31];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, advanced once per frame
  int mx, my, mdir, manim, mcnt, mmov, mpv, mpd;

  always #5 clk = ~clk;

  pacman_motion_if qif ();
  assign qif.query_wall = wall_map[qif.query_row][qif.query_col];

  pacman_motion dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .frame_tick       (frame_tick),
    .req_valid        (req_valid),
    .req_dir          (req_dir),
    .qry              (qif),
    .pacman_xloc      (pacman_xloc),
    .pacman_yloc      (pacman_yloc),
    .pacman_dir       (pacman_dir),
    .pacman_animation (pacman_animation),
    .moving           (moving)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"}, 32'(pacman_xloc), 32'(mx));
    check({tag, ".y"}, 32'(pacman_yloc), 32'(my));
    check({tag, ".dir"}, 32'(pacman_dir), 32'(mdir));
    check({tag, ".anim"}, 32'(pacman_animation), 32'(manim));
    check({tag, ".moving"}, 32'(moving), 32'(mmov));
  endtask

  task automatic model_reset();
    mx = 119; my = 228; mdir = 1; manim = 0; mcnt = 0; mmov = 0; mpv = 0; mpd = 1;
  endtask

  function automatic logic nb_wall(input int x, input int y, input int d);
    int col, row;
    col = x / 8;
    row = y / 8;
    case (d)
      0: col = (col + 1) % (MAZE_W / 8);
      1: col = (col + MAZE_W / 8 - 1) % (MAZE_W / 8);
      2: row = row - 1;
      default: row = row + 1;
    endcase
    return wall_map[row & 31][col];
  endfunction

  task automatic model_frame(input bit en);
    bit centred;
    if (!en) return;
    if (mmov != 0) begin
      mcnt++;
      if (mcnt == ANIM_DIV) begin
        mcnt  = 0;
        manim = (manim + 1) % 4;
      end
    end
    centred = (mx % 8 == 7) && (my % 8 == 4);
    if (mpv != 0 && mpd == (mdir ^ 1)) begin
      mdir = mpd; mpv = 0;
    end else if (mpv != 0 && mpd != mdir && centred && !nb_wall(mx, my, mpd)) begin
      mdir = mpd; mpv = 0;
    end
    if (centred && nb_wall(mx, my, mdir)) begin
      mmov = 0;
    end else begin
      mmov = 1;
      case (mdir)
        0: mx = (mx + 1) % MAZE_W;
        1: mx = (mx + MAZE_W - 1) % MAZE_W;
        2: my = (my + 1023) % 1024;
        default: my = (my + 1) % 1024;
      endcase
    end
`ifndef PACMAN_TURN_BUFFER_EN
    mpv = 0;
`endif
  endtask

  task automatic req(input int d);
    req_valid = 1'b1;
    req_dir   = 2'(d);
    cyc();
    req_valid = 1'b0;
    mpv = 1;
    mpd = d;
  endtask

  task automatic tick(input bit en, input int extra);
    enable     = en;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    enable     = 1'b1;
    cyc(); cyc(); cyc();
    repeat (extra) cyc();
    model_frame(en);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".x"}, 32'(pacman_xloc), 32'd119);
    check({tag, ".y"}, 32'(pacman_yloc), 32'd228);
    check({tag, ".dir"}, 32'(pacman_dir), 32'd1);
    check({tag, ".anim"}, 32'(pacman_animation), 32'd0);
    check({tag, ".moving"}, 32'(moving), 32'd0);
    check({tag, ".qcol"}, 32'(qif.query_col), 32'd14);
    check({tag, ".qrow"}, 32'(qif.query_row), 32'd28);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        wall_map[r][c] = 1'b0;
    rst = 1'b0; enable = 1'b0; frame_tick = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
    cyc(); cyc();
    rst = 1'b1;
    model_reset();
    check_reset("reset");

    // Open corridor, ten frames
    repeat (10) tick(1'b1, 0);
    check_all("corridor");
    check("corridor.x_abs", 32'(pacman_xloc), 32'd109);
    check("corridor.anim_abs", 32'(pacman_animation), 32'd2);
    check("corridor.moving_abs", 32'(moving), 32'd1);

    // Wall ahead at the centre x=103: stop there and freeze the mouth
    wall_map[28][11] = 1'b1;
    repeat (7) tick(1'b1, 0);
    check_all("wall_stop");
    check("wall_stop.x_abs", 32'(pacman_xloc), 32'd103);
    repeat (3) tick(1'b1, 1);
    check_all("wall_hold");
    check("wall_hold.moving_abs", 32'(moving), 32'd0);
    check("wall_hold.anim_abs", 32'(pacman_animation), 32'd0);
    wall_map[28][11] = 1'b0;

    // Reset landing on the FWD cycle of a frame
    enable = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    model_reset();
    check_reset("mid_reset");

    // Reversal between centres
    tick(1'b1, 0);
    tick(1'b1, 0);
    check("rev.pre_x", 32'(pacman_xloc), 32'd117);
    req(0);
    tick(1'b1, 0);
    check_all("reversal");
    check("reversal.x_abs", 32'(pacman_xloc), 32'd118);
    check("reversal.dir_abs", 32'(pacman_dir), 32'd0);

    // Early UP request while heading LEFT towards the centre x=119
    repeat (5) tick(1'b1, 0);
    req(1);
    tick(1'b1, 0);
    check("buf.pre_x", 32'(pacman_xloc), 32'd122);
    req(2);
    repeat (4) tick(1'b1, 0);
    check_all("buffered");
`ifdef PACMAN_TURN_BUFFER_EN
    check("buffered.x_abs", 32'(pacman_xloc), 32'd119);
    check("buffered.y_abs", 32'(pacman_yloc), 32'd227);
    check("buffered.dir_abs", 32'(pacman_dir), 32'd2);
`else
    check("buffered.x_abs", 32'(pacman_xloc), 32'd118);
    check("buffered.y_abs", 32'(pacman_yloc), 32'd228);
    check("buffered.dir_abs", 32'(pacman_dir), 32'd1);
`endif

    // Tunnel: climb to row 14, then run left through x=0
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    model_reset();
    req(2);
    for (int i = 0; i < 200 && my != 116; i++) tick(1'b1, 0);
    check("tunnel.y_row", 32'(pacman_yloc), 32'd116);
    req(1);
    for (int i = 0; i < 200 && mx != 0; i++) tick(1'b1, 0);
    check_all("tunnel_edge");
    check("tunnel_edge.x_abs", 32'(pacman_xloc), 32'd0);
    tick(1'b1, 0);
    check_all("tunnel_wrap");
    check("tunnel_wrap.x_abs", 32'(pacman_xloc), 32'd223);
    check("tunnel_wrap.y_abs", 32'(pacman_yloc), 32'd116);

    // Random maze with solid top/bottom border, random requests and enable gaps
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        wall_map[r][c] = (r == 0 || r >= 30) ? 1'b1 : ($urandom_range(0, 3) == 0);
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 1) == 1) req(int'($urandom_range(0, 3)));
      tick($urandom_range(0, 7) != 0, int'($urandom_range(0, 2)));
      check_all($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
